// File: rtl/ltc2333_pkg.sv
// Shared types, widths and helpers for the LTC2333 read stage.
package ltc2333_pkg;

   localparam int unsigned WORD_BITS = 24;
   localparam int unsigned CHAN_N    = 8;
   localparam int unsigned TDATA_W   = 32;
   localparam int unsigned FIFO_W    = TDATA_W + 1;

   // One LTC2333 result word as it comes off a lane, MSB first.
   typedef struct packed {
      logic [17:0] data;
      logic [2:0]  chan_id;
      logic [2:0]  softspan;
   } ltc2333_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PUSH0 = 2'd2,
      PUSH1 = 2'd3
   } rd_state_e;

   // Number of enabled channels in a mask.
   function automatic logic [3:0] popcount8(input logic [7:0] m);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, m[i]};
      end
      return c;
   endfunction

   // Channel number of the n-th set bit of the mask, LSB first.
   function automatic logic [2:0] nth_set_bit(input logic [7:0] m, input logic [2:0] n);
      logic [3:0] seen;
      logic [2:0] idx;
      logic       found;
      seen  = 4'd0;
      idx   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (m[i] && !found) begin
            if (seen == {1'b0, n}) begin
               idx   = 3'(i);
               found = 1'b1;
            end
            seen = seen + 4'd1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ltc2333_sync_fifo.sv
// Synchronous FIFO with a registered fall-through output stage.
// Capacity counts the output register, so DEPTH entries total.
module ltc2333_sync_fifo #(
   parameter int unsigned W     = 33,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         rd_valid_o,
   output logic         wr_accept_c_o,
   output logic         nonempty_nx_c_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   mem_cnt_q, mem_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [AW:0]   total_c;
   logic          pop_c, wr_c, load_c, full_c;

   // Occupancy, pointer and output-stage next state; pop frees space before push.
   always_comb begin
      pop_c       = rd_en_i && out_valid_q;
      total_c     = mem_cnt_q + (AW+1)'(out_valid_q);
      full_c      = (total_c == (AW+1)'(DEPTH));
      wr_accept_c_o = !full_c || pop_c;
      wr_c        = wr_en_i && wr_accept_c_o;
      load_c      = (mem_cnt_q != '0) && (!out_valid_q || pop_c);
      wr_ptr_d    = wr_c   ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = load_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
      mem_cnt_d   = mem_cnt_q + (AW+1)'(wr_c) - (AW+1)'(load_c);
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (load_c) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_q[rd_ptr_q];
      end else if (pop_c) begin
         out_valid_d = 1'b0;
      end
      nonempty_nx_c_o = (mem_cnt_d != '0) || out_valid_d;
   end

   // Storage array; no reset needed, occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (wr_c) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign rd_data_o  = out_data_q;
   assign rd_valid_o = out_valid_q;

endmodule

// File: rtl/ltc2333_read.sv
// LTC2333 read stage: deserialise two SDO lanes into tagged words,
// check channel IDs and stream them out over AXI-Stream.
module ltc2333_read
   import ltc2333_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic [7:0]         active_channels,
   input  logic               bit_strobe,
   input  logic [1:0]         sdo,
   output logic [31:0]        m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic               busy,
   output logic [CNT_W-1:0]   overflow_cnt,
   output logic [CNT_W-1:0]   chid_err_cnt
);

   rd_state_e            state_q, state_d;
   logic [7:0]           mask_q, mask_d;
   logic [3:0]           n_words_q, n_words_d;
   logic [2:0]           word_idx_q, word_idx_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0] sr0_q, sr0_d;
   logic [WORD_BITS-1:0] sr1_q, sr1_d;
   logic [CNT_W-1:0]     chid_err_q, chid_err_d;
   logic [CNT_W-1:0]     ovf_q, ovf_d;
   logic                 busy_q;

   ltc2333_word_t        lane0_w, lane1_w;
   logic [2:0]           exp_id_c;
   logic                 last_word_c;
   logic                 push_c;
   logic [FIFO_W-1:0]    push_data_c;
   logic [FIFO_W-1:0]    fifo_out;
   logic                 fifo_valid;
   logic                 fifo_accept_c;
   logic                 fifo_nonempty_nx_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign lane0_w  = ltc2333_word_t'(sr0_q);
   assign lane1_w  = ltc2333_word_t'(sr1_q);
   assign exp_id_c = nth_set_bit(mask_q, word_idx_q);

   // Next-state, shift-register, push and counter logic.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      n_words_d   = n_words_q;
      word_idx_d  = word_idx_q;
      bit_cnt_d   = bit_cnt_q;
      sr0_d       = sr0_q;
      sr1_d       = sr1_q;
      chid_err_d  = chid_err_q;
      ovf_d       = ovf_q;
      push_c      = 1'b0;
      push_data_c = '0;
      last_word_c = ({1'b0, word_idx_q} == (n_words_q - 4'd1));

      unique case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            if (bit_strobe) begin
               sr0_d     = {sr0_q[WORD_BITS-2:0], sdo[0]};
               sr1_d     = {sr1_q[WORD_BITS-2:0], sdo[1]};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(WORD_BITS - 1)) begin
                  state_d = PUSH0;
               end
            end
         end
         PUSH0: begin
            push_c      = 1'b1;
            push_data_c = {1'b0, 1'b0, 7'b0, lane0_w};
            if (lane0_w.chan_id != exp_id_c) begin
               chid_err_d = sat_inc(chid_err_q);
            end
            state_d = PUSH1;
         end
         PUSH1: begin
            push_c      = 1'b1;
            push_data_c = {last_word_c, 1'b1, 7'b0, lane1_w};
            if (lane1_w.chan_id != exp_id_c) begin
               chid_err_d = sat_inc(chid_err_q);
            end
            if (last_word_c) begin
               state_d = IDLE;
            end else begin
               state_d    = SHIFT;
               word_idx_d = word_idx_q + 3'd1;
               bit_cnt_d  = 5'd0;
               // First bit of the next word may already arrive here.
               if (bit_strobe) begin
                  sr0_d     = {sr0_q[WORD_BITS-2:0], sdo[0]};
                  sr1_d     = {sr1_q[WORD_BITS-2:0], sdo[1]};
                  bit_cnt_d = 5'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new frame overrides whatever the current one was doing.
      if (frame_start) begin
         push_c     = 1'b0;
         chid_err_d = chid_err_q;
         word_idx_d = 3'd0;
         bit_cnt_d  = 5'd0;
         sr0_d      = '0;
         sr1_d      = '0;
         if (active_channels != 8'd0) begin
            state_d   = SHIFT;
            mask_d    = active_channels;
            n_words_d = popcount8(active_channels);
         end else begin
            state_d    = IDLE;
            chid_err_d = sat_inc(chid_err_q);
         end
      end

      if (push_c && !fifo_accept_c) begin
         ovf_d = sat_inc(ovf_q);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         n_words_q  <= '0;
         word_idx_q <= '0;
         bit_cnt_q  <= '0;
         sr0_q      <= '0;
         sr1_q      <= '0;
         chid_err_q <= '0;
         ovf_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         n_words_q  <= n_words_d;
         word_idx_q <= word_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         sr0_q      <= sr0_d;
         sr1_q      <= sr1_d;
         chid_err_q <= chid_err_d;
         ovf_q      <= ovf_d;
         busy_q     <= (state_d != IDLE) || fifo_nonempty_nx_c;
      end
   end

   ltc2333_sync_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i           (clk),
      .reset_i         (reset),
      .wr_en_i         (push_c),
      .wr_data_i       (push_data_c),
      .rd_en_i         (m_axis_tready),
      .rd_data_o       (fifo_out),
      .rd_valid_o      (fifo_valid),
      .wr_accept_c_o   (fifo_accept_c),
      .nonempty_nx_c_o (fifo_nonempty_nx_c)
   );

   assign m_axis_tdata  = fifo_out[TDATA_W-1:0];
   assign m_axis_tlast  = fifo_out[TDATA_W];
   assign m_axis_tvalid = fifo_valid;
   assign busy          = busy_q;
   assign overflow_cnt  = ovf_q;
   assign chid_err_cnt  = chid_err_q;

endmodule

// File: tb/tb_ltc2333_read.sv
// Scoreboard bench for ltc2333_read: directed frames, expected beats queued at send time.
module tb_ltc2333_read;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [7:0]  active_channels;
   logic        bit_strobe;
   logic [1:0]  sdo;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic [15:0] overflow_cnt;
   logic [15:0] chid_err_cnt;

   int checks = 0;
   int errors = 0;
   int exp_chid = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   ltc2333_read #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .frame_start     (frame_start),
      .active_channels (active_channels),
      .bit_strobe      (bit_strobe),
      .sdo             (sdo),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .busy            (busy),
      .overflow_cnt    (overflow_cnt),
      .chid_err_cnt    (chid_err_cnt)
   );

   // Monitor: every accepted beat is compared with the head of the queue.
   always @(negedge clk) begin
      if (!reset && m_axis_tvalid && m_axis_tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected beat got %h", {m_axis_tlast, m_axis_tdata});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({m_axis_tlast, m_axis_tdata} !== e) begin
               errors++;
               $display("FAIL beat: got %h expected %h", {m_axis_tlast, m_axis_tdata}, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] mkw(input logic [17:0] d, input logic [2:0] id, input logic [2:0] ss);
      return {d, id, ss};
   endfunction

   task automatic push_exp(input logic lane, input logic [23:0] w, input logic last);
      exp_q.push_back({last, lane, 7'b0, w});
   endtask

   task automatic frame(input logic [7:0] m);
      frame_start     = 1'b1;
      active_channels = m;
      step();
      frame_start     = 1'b0;
   endtask

   task automatic send_bits(input logic [23:0] w0, input logic [23:0] w1, input int nbits);
      for (int b = 23; b > 23 - nbits; b--) begin
         sdo        = {w1[b], w0[b]};
         bit_strobe = 1'b1;
         step();
         bit_strobe = 1'b0;
         step();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
      end
      step();
      step();
      chk("tvalid_idle", 33'(m_axis_tvalid), 33'd0);
      chk("busy_idle", 33'(busy), 33'd0);
   endtask

   initial begin
      logic [23:0] a, b;

      reset           = 1'b1;
      frame_start     = 1'b0;
      active_channels = 8'd0;
      bit_strobe      = 1'b0;
      sdo             = 2'b00;
      m_axis_tready   = 1'b1;
      repeat (3) step();
      chk("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
      chk("rst_busy", 33'(busy), 33'd0);
      chk("rst_ovf", 33'(overflow_cnt), 33'd0);
      chk("rst_chid", 33'(chid_err_cnt), 33'd0);
      reset = 1'b0;
      step();

      // Test 1: all eight channels, correct IDs, 16 beats, tlast on the last.
      frame(8'hFF);
      for (int i = 0; i < 8; i++) begin
         a = mkw(18'h30000 | 18'(i), 3'(i), 3'd1);
         b = mkw(18'h05A00 + 18'(i), 3'(i), 3'd6);
         push_exp(1'b0, a, 1'b0);
         push_exp(1'b1, b, (i == 7));
         send_bits(a, b, 24);
      end
      drain();
      chk("t1_chid", 33'(chid_err_cnt), 33'(exp_chid));

      // Test 2: mask 0x22 -> channels 1 and 5.
      frame(8'h22);
      a = 24'hABCD4A;
      b = mkw(18'h01234, 3'd1, 3'd2);
      push_exp(1'b0, a, 1'b0);
      push_exp(1'b1, b, 1'b0);
      send_bits(a, b, 24);
      a = mkw(18'h2AAAA, 3'd5, 3'd0);
      b = mkw(18'h15555, 3'd5, 3'd7);
      push_exp(1'b0, a, 1'b0);
      push_exp(1'b1, b, 1'b1);
      send_bits(a, b, 24);
      drain();
      chk("t2_chid", 33'(chid_err_cnt), 33'(exp_chid));

      // Test 3: lane 1 reports the wrong ID; latency of lane-0 word is two clocks.
      frame(8'h01);
      chk("t3_busy", 33'(busy), 33'd1);
      a = mkw(18'h3FFFF, 3'd0, 3'd0);
      b = mkw(18'h00001, 3'd3, 3'd0);
      push_exp(1'b0, a, 1'b0);
      push_exp(1'b1, b, 1'b1);
      exp_chid++;
      send_bits(a, b, 24);
      chk("t3_lat1", 33'(m_axis_tvalid), 33'd0);
      step();
      chk("t3_lat2", 33'(m_axis_tvalid), 33'd1);
      drain();
      chk("t3_chid", 33'(chid_err_cnt), 33'(exp_chid));

      // Empty mask: no frame, one ID error.
      frame(8'h00);
      step();
      exp_chid++;
      chk("m0_chid", 33'(chid_err_cnt), 33'(exp_chid));
      chk("m0_busy", 33'(busy), 33'd0);

      // Test 4: stalled sink, only the first 8 lane words fit.
      m_axis_tready = 1'b0;
      frame(8'hFF);
      for (int i = 0; i < 8; i++) begin
         a = mkw(18'h11111 + 18'(i), 3'(i), 3'd3);
         b = mkw(18'h22222 + 18'(i), 3'(i), 3'd4);
         if (i < 4) begin
            push_exp(1'b0, a, 1'b0);
            push_exp(1'b1, b, 1'b0);
         end
         send_bits(a, b, 24);
      end
      repeat (3) step();
      chk("t4_ovf", 33'(overflow_cnt), 33'd8);
      chk("t4_tvalid", 33'(m_axis_tvalid), 33'd1);
      chk("t4_head", {m_axis_tlast, m_axis_tdata}, {1'b0, 1'b0, 7'b0, mkw(18'h11111, 3'd0, 3'd3)});
      m_axis_tready = 1'b1;
      drain();
      chk("t4_chid", 33'(chid_err_cnt), 33'(exp_chid));

      // Test 5: reset in the middle of word 2 clears everything.
      m_axis_tready = 1'b0;
      frame(8'hFF);
      send_bits(mkw(18'h00100, 3'd0, 3'd0), mkw(18'h00200, 3'd0, 3'd0), 24);
      send_bits(mkw(18'h00300, 3'd1, 3'd0), mkw(18'h00400, 3'd6, 3'd0), 24);
      send_bits(mkw(18'h3C3C3, 3'd2, 3'd0), mkw(18'h0F0F0, 3'd2, 3'd0), 12);
      reset = 1'b1;
      step();
      chk("t5_tvalid", 33'(m_axis_tvalid), 33'd0);
      chk("t5_tdata", {m_axis_tlast, m_axis_tdata}, 33'd0);
      chk("t5_busy", 33'(busy), 33'd0);
      chk("t5_ovf", 33'(overflow_cnt), 33'd0);
      chk("t5_chid", 33'(chid_err_cnt), 33'd0);
      reset    = 1'b0;
      exp_chid = 0;
      exp_q.delete();
      m_axis_tready = 1'b1;
      step();
      frame(8'h01);
      a = mkw(18'h12345, 3'd0, 3'd5);
      b = mkw(18'h2468A, 3'd0, 3'd2);
      push_exp(1'b0, a, 1'b0);
      push_exp(1'b1, b, 1'b1);
      send_bits(a, b, 24);
      drain();

      // Test 6: restart mid-frame keeps queued words; new frame on channel 7.
      m_axis_tready = 1'b0;
      frame(8'h0F);
      for (int i = 0; i < 2; i++) begin
         a = mkw(18'h0ABC0 + 18'(i), 3'(i), 3'd1);
         b = mkw(18'h0DEF0 + 18'(i), 3'(i), 3'd2);
         push_exp(1'b0, a, 1'b0);
         push_exp(1'b1, b, 1'b0);
         send_bits(a, b, 24);
      end
      send_bits(mkw(18'h3FFFF, 3'd2, 3'd7), mkw(18'h3FFFF, 3'd2, 3'd7), 10);
      frame(8'h80);
      a = mkw(18'h1E1E1, 3'd7, 3'd3);
      b = mkw(18'h2D2D2, 3'd7, 3'd4);
      push_exp(1'b0, a, 1'b0);
      push_exp(1'b1, b, 1'b1);
      send_bits(a, b, 24);
      step();
      chk("t6_busy", 33'(busy), 33'd1);
      m_axis_tready = 1'b1;
      drain();
      chk("t6_chid", 33'(chid_err_cnt), 33'(exp_chid));
      chk("t6_ovf", 33'(overflow_cnt), 33'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
